// File: rtl/wave_pwm_dac.sv
// PWM DAC stage: re-times 8-bit offset-binary samples onto fixed PWM frame
// boundaries through a one-entry holding buffer, with volume about midscale.
module wave_pwm_dac #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic             sample_ready,
    input  logic [2:0]       atten,
    input  logic             underrun_clr,
    output logic             pwm_out,
    output logic             frame_start,
    output logic             underrun
);

    localparam int              PW     = $clog2(PRESCALE + 1);
    localparam logic [PW-1:0]   P_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] MID   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] C_LAST = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_hold;
    logic               r_hold_full;
    logic [WIDTH-1:0]   r_duty;
    logic [PW-1:0]      r_presc;
    logic [WIDTH-1:0]   r_cnt;
    logic               r_pwm;
    logic               r_frame_start;
    logic               r_underrun;

    logic               w_run;
    logic               w_tick;
    logic               w_load;
    logic               w_accept;
    logic signed [WIDTH:0] w_diff;
    logic [WIDTH-1:0]   w_duty_new;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (enable)  w_state_next = RUN;
            RUN:     if (!enable) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Running only while still enabled: a RUN->IDLE cycle already behaves as idle.
    assign w_run    = (r_state == RUN) && enable;
    assign w_tick   = (r_presc == P_LAST);
    assign w_load   = ((r_state == IDLE) && enable) || (w_run && w_tick && (r_cnt == C_LAST));
    assign w_accept = sample_valid && !r_hold_full;

    // Signed attenuation about midscale, one bit wider than the sample.
    assign w_diff     = $signed({1'b0, r_hold}) - $signed({1'b0, MID});
    assign w_duty_new = WIDTH'($signed({1'b0, MID}) + (w_diff >>> atten));

    always_ff @(posedge clk_50MHz) begin
        if (reset) begin
            r_state       <= IDLE;
            r_hold        <= '0;
            r_hold_full   <= 1'b0;
            r_duty        <= MID;
            r_presc       <= '0;
            r_cnt         <= '0;
            r_pwm         <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_frame_start <= w_load;
            r_pwm         <= w_run && (r_cnt < r_duty);

            if (w_run) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_cnt   <= r_cnt + 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end else begin
                r_presc <= '0;
                r_cnt   <= '0;
            end

            // Load drains only a full buffer; accept fills only an empty one.
            if (w_load && r_hold_full) begin
                r_duty      <= w_duty_new;
                r_hold_full <= 1'b0;
            end else if (w_accept) begin
                r_hold      <= sample_in;
                r_hold_full <= 1'b1;
            end

            if (w_load && !r_hold_full)
                r_underrun <= 1'b1;
            else if (underrun_clr)
                r_underrun <= 1'b0;
        end
    end

    assign sample_ready = !r_hold_full;
    assign pwm_out      = r_pwm;
    assign frame_start  = r_frame_start;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_wave_pwm_dac.sv
// Scoreboard bench for wave_pwm_dac: expected duties are queued when samples
// are accepted and checked against the measured high time of each frame.
module tb_wave_pwm_dac;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1, enable = 1'b0, sample_valid = 1'b0, underrun_clr = 1'b0;
    logic [7:0] sample_in = '0;
    logic [2:0] atten = '0;
    logic       sample_ready, pwm, fs, underrun;

    logic       p_reset = 1'b1, p_enable = 1'b0, p_valid = 1'b0;
    logic [7:0] p_sample = '0;
    logic       p_ready, p_pwm, p_fs, p_underrun;

    wave_pwm_dac #(.WIDTH(8), .PRESCALE(1)) dut (
        .clk_50MHz(clk), .reset(reset), .enable(enable), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_ready(sample_ready), .atten(atten),
        .underrun_clr(underrun_clr), .pwm_out(pwm), .frame_start(fs), .underrun(underrun)
    );

    wave_pwm_dac #(.WIDTH(8), .PRESCALE(4)) dut4 (
        .clk_50MHz(clk), .reset(p_reset), .enable(p_enable), .sample_in(p_sample),
        .sample_valid(p_valid), .sample_ready(p_ready), .atten(3'd0),
        .underrun_clr(1'b0), .pwm_out(p_pwm), .frame_start(p_fs), .underrun(p_underrun)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int last_duty = 128;

    function automatic int model_duty(input int s, input int a);
        int d;
        d = s - 128;
        d = d >>> a;
        return 128 + d;
    endfunction

    task automatic wait_fs(input bit sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ((sel ? p_fs : fs) === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic measure(input bit sel, input int n, output int hi, output int run, output int fs_at);
        bit lead;
        bit b;
        lead = 1'b1; hi = 0; run = 0; fs_at = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            b = sel ? p_pwm : pwm;
            if (b === 1'b1) hi++;
            if (b === 1'b1 && lead) run++; else lead = 1'b0;
            if (fs_at < 0 && (sel ? p_fs : fs) === 1'b1) fs_at = i;
        end
    endtask

    task automatic push_sample(input int s, input int a);
        bit done;
        done = 1'b0;
        sample_in = 8'(s); atten = 3'(a); sample_valid = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (sample_ready === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        if (done) exp_q.push_back(model_duty(s, a));
        else begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout: sample %0d never accepted (ready stuck at %b, required 1)", s, sample_ready);
        end
    endtask

    task automatic pop_exp(input string name, output int e);
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++; e = -1;
            $display("FAIL %s: scoreboard empty at frame_start, required a queued duty", name);
        end else e = exp_q.pop_front();
    endtask

    task automatic expect_fs(input bit sel, input string name);
        bit ok;
        wait_fs(sel, ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s: frame_start not seen within budget, got %b required 1", name, ok);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (pwm !== 1'b0) begin n_err++; $display("FAIL reset_pwm: got %b required 0", pwm); end
        n_cmp++; if (fs !== 1'b0) begin n_err++; $display("FAIL reset_fs: got %b required 0", fs); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL reset_underrun: got %b required 0", underrun); end
        n_cmp++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b required 1", sample_ready); end
    endtask

    task automatic test_duty_count;
        int e, hi, run, fa;
        push_sample(200, 0);
        enable = 1'b1;
        expect_fs(1'b0, "duty_fs");
        pop_exp("duty_pop", e);
        fork
            measure(1'b0, 256, hi, run, fa);
            push_sample(255, 1);
        join
        n_cmp++; if (hi !== e) begin n_err++; $display("FAIL duty_high: got %0d required %0d", hi, e); end
        n_cmp++; if (run !== e) begin n_err++; $display("FAIL duty_leading: got %0d required %0d", run, e); end
        n_cmp++; if (fa !== 256) begin n_err++; $display("FAIL duty_period: got %0d required 256", fa); end
    endtask

    task automatic test_atten;
        int s_tab[3] = '{255, 0, 128};
        int a_tab[3] = '{1, 2, 5};
        int e, hi, run, fa;
        for (int i = 0; i < 3; i++) begin
            expect_fs(1'b0, "atten_fs");
            n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL atten_underrun: frame %0d got %b required 0", i, underrun); end
            pop_exp("atten_pop", e);
            fork
                measure(1'b0, 256, hi, run, fa);
                if (i < 2) push_sample(s_tab[i+1], a_tab[i+1]);
            join
            n_cmp++; if (hi !== e) begin n_err++; $display("FAIL atten_high: sample %0d got %0d required %0d", s_tab[i], hi, e); end
            last_duty = e;
        end
    endtask

    task automatic test_underrun;
        int hi, run, fa;
        expect_fs(1'b0, "underrun_fs");
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_set: got %b required 1", underrun); end
        measure(1'b0, 256, hi, run, fa);
        n_cmp++; if (hi !== last_duty) begin n_err++; $display("FAIL underrun_repeat: got %0d required %0d", hi, last_duty); end
        repeat (10) @(negedge clk);
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL underrun_sticky: got %b required 1", underrun); end
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_clr: got %b required 0", underrun); end
    endtask

    task automatic test_back_to_back;
        int e, hi, run, fa;
        sample_in = 8'd10; atten = 3'd0; sample_valid = 1'b1;
        n_cmp++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_first: got %b required 1", sample_ready); end
        @(negedge clk);
        exp_q.push_back(model_duty(10, 0));
        sample_in = 8'd20;
        n_cmp++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_drop: got %b required 0", sample_ready); end
        @(negedge clk);
        n_cmp++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_hold: got %b required 0", sample_ready); end
        expect_fs(1'b0, "bp_fs1");
        n_cmp++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after_fs: got %b required 1", sample_ready); end
        pop_exp("bp_pop1", e);
        fork
            measure(1'b0, 256, hi, run, fa);
            begin
                @(negedge clk);
                n_cmp++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL bp_second_accept: ready got %b required 0", sample_ready); end
                exp_q.push_back(model_duty(20, 0));
                sample_valid = 1'b0;
            end
        join
        n_cmp++; if (hi !== e) begin n_err++; $display("FAIL bp_frame1: got %0d required %0d", hi, e); end
        expect_fs(1'b0, "bp_fs2");
        pop_exp("bp_pop2", e);
        measure(1'b0, 256, hi, run, fa);
        n_cmp++; if (hi !== e) begin n_err++; $display("FAIL bp_frame2: got %0d required %0d", hi, e); end
    endtask

    task automatic test_disable;
        int e, hi, run, fa;
        int bad;
        push_sample(100, 0);
        expect_fs(1'b0, "dis_fs");
        pop_exp("dis_pop", e);
        repeat (50) @(negedge clk);
        n_cmp++; if (pwm !== 1'b1) begin n_err++; $display("FAIL dis_pwm_before: got %b required 1", pwm); end
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (pwm !== 1'b0) begin n_err++; $display("FAIL dis_pwm_off: got %b required 0", pwm); end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (pwm !== 1'b0 || fs !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL dis_idle: active cycles got %0d required 0", bad); end
        push_sample(30, 0);
        enable = 1'b1;
        @(negedge clk);
        n_cmp++; if (fs !== 1'b1) begin n_err++; $display("FAIL dis_reenable_fs: got %b required 1", fs); end
        pop_exp("dis_pop2", e);
        measure(1'b0, 256, hi, run, fa);
        n_cmp++; if (hi !== e) begin n_err++; $display("FAIL dis_frame_high: got %0d required %0d", hi, e); end
        n_cmp++; if (run !== e) begin n_err++; $display("FAIL dis_frame_leading: got %0d required %0d", run, e); end
    endtask

    task automatic test_reset_midframe;
        int hi, run, fa;
        push_sample(77, 0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        reset = 1'b1; enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (pwm !== 1'b0) begin n_err++; $display("FAIL rst_mid_pwm: got %b required 0", pwm); end
        n_cmp++; if (fs !== 1'b0) begin n_err++; $display("FAIL rst_mid_fs: got %b required 0", fs); end
        n_cmp++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_mid_underrun: got %b required 0", underrun); end
        n_cmp++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready: got %b required 1", sample_ready); end
        reset = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        expect_fs(1'b0, "rst_mid_fs2");
        n_cmp++; if (underrun !== 1'b1) begin n_err++; $display("FAIL rst_mid_discard: underrun got %b required 1", underrun); end
        measure(1'b0, 256, hi, run, fa);
        n_cmp++; if (hi !== 128) begin n_err++; $display("FAIL rst_mid_duty: got %0d required 128", hi); end
        enable = 1'b0;
    endtask

    task automatic test_prescale;
        int e, hi, run, fa;
        p_reset = 1'b1;
        repeat (2) @(negedge clk);
        p_reset = 1'b0;
        p_sample = 8'd64; p_valid = 1'b1;
        @(negedge clk);
        p_valid = 1'b0;
        n_cmp++; if (p_ready !== 1'b0) begin n_err++; $display("FAIL ps_accept: ready got %b required 0", p_ready); end
        exp_q.push_back(model_duty(64, 0));
        p_enable = 1'b1;
        expect_fs(1'b1, "ps_fs");
        pop_exp("ps_pop", e);
        measure(1'b1, 1024, hi, run, fa);
        n_cmp++; if (hi !== e * 4) begin n_err++; $display("FAIL ps_high: got %0d required %0d", hi, e * 4); end
        n_cmp++; if (fa !== 1024) begin n_err++; $display("FAIL ps_period: got %0d required 1024", fa); end
        p_enable = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_duty_count();
        test_atten();
        test_underrun();
        test_back_to_back();
        test_disable();
        test_reset_midframe();
        test_prescale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
